rc4_prga_decrypt: RTL

RC4 pseudo-random generation and decrypt stage. It consumes the 256-byte S-array that the key-scheduling loop left in S-RAM. It generates one keystream byte per message byte, XORs each keystream byte with the encrypted-message ROM, and writes the plaintext to the decrypted-message RAM. The block sits after the key-scheduling loop in the top-level sequencer and uses the same level start_flag/done_flag handshake.

---
 rtl/rc4_pkg.sv | 34 +++
 rtl/rc4_byte_check.sv | 14 +
 rtl/rc4_prga_decrypt.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 keystream / decrypt stage.
//   byte_t      : 8-bit data/address type used by every RC4 block
//   state_t     : PRGA/decrypt FSM state encoding
//   S_SIZE      : number of entries in the S-array
//   ASCII_*     : bounds of the plaintext character set (space, 'a'..'z')
package rc4_pkg;

    typedef logic [7:0] byte_t;

    localparam int    S_SIZE      = 256;
    localparam byte_t ASCII_SPACE = 8'h20;
    localparam byte_t ASCII_LO    = 8'h61;
    localparam byte_t ASCII_HI    = 8'h7A;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INC_I,
        ST_READ_I,
        ST_WAIT_I,
        ST_SAVE_I,
        ST_SET_J,
        ST_READ_J,
        ST_WAIT_J,
        ST_SAVE_J,
        ST_WRITE_I,
        ST_WRITE_J,
        ST_READ_F,
        ST_WAIT_F,
        ST_SAVE_F,
        ST_WRITE_DEC,
        ST_FINISH
    } state_t;

endpackage

// File: rtl/rc4_byte_check.sv
// Plaintext character filter: passes a space or a lowercase letter.
// Ports:
//   data : decrypted byte under test
//   pass : 1 when data is 0x20 or within 0x61..0x7A
module rc4_byte_check
    import rc4_pkg::*;
(
    input  logic [7:0] data,
    output logic       pass
);

    assign pass = (data == ASCII_SPACE) || ((data >= ASCII_LO) && (data <= ASCII_HI));

endmodule

// File: rtl/rc4_prga_decrypt.sv
// RC4 pseudo-random generation + decrypt stage. Walks the S-array left in
// S-RAM by the key schedule, produces one keystream byte per message byte,
// XORs it with the encrypted ROM and writes plaintext to the decrypted RAM.
// Build option: RC4_PRGA_ASCII_CHECK_EN stops the run at the first written
// byte that is not a space or lowercase letter and reports valid_flag=0.
//
// Parameters:
//   MSG_LEN  : message bytes to decrypt (1..256)
//   READ_LAT : wait cycles between presenting an address and sampling q
// Ports:
//   clk, reset (async, active-high)
//   start_flag (in, level) / done_flag, valid_flag (out)
//   s_address, s_data, s_wren, s_q        : S-RAM
//   enc_address, enc_q                    : encrypted-message ROM
//   dec_address, dec_data, dec_wren       : decrypted-message RAM
//
// state      | meaning
// -----------+------------------------------------------------
// IDLE       | held while start_flag=0; i, j, k cleared
// INC_I      | i += 1
// READ_I     | present S[i] address
// WAIT_I     | read latency for S[i]
// SAVE_I     | capture si
// SET_J      | j += si
// READ_J     | present S[j] address
// WAIT_J     | read latency for S[j]
// SAVE_J     | capture sj
// WRITE_I    | S[i] <= sj
// WRITE_J    | S[j] <= si (lands last, so i==j leaves S[i] intact)
// READ_F     | present S[si+sj] and enc[k]
// WAIT_F     | read latency for f and e
// SAVE_F     | capture f and e
// WRITE_DEC  | dec[k] <= f^e, k += 1
// FINISH     | done_flag held until start_flag drops
module rc4_prga_decrypt
    import rc4_pkg::*;
#(
    parameter int MSG_LEN  = 32,
    parameter int READ_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_flag,
    output logic       done_flag,
    output logic       valid_flag,
    output logic [7:0] s_address,
    output logic [7:0] s_data,
    output logic       s_wren,
    input  logic [7:0] s_q,
    output logic [7:0] enc_address,
    input  logic [7:0] enc_q,
    output logic [7:0] dec_address,
    output logic [7:0] dec_data,
    output logic       dec_wren
);

    localparam int         MSG_LEN_C   = (MSG_LEN > S_SIZE) ? S_SIZE : ((MSG_LEN < 1) ? 1 : MSG_LEN);
    localparam logic [8:0] K_LAST      = 9'(MSG_LEN_C);
    localparam bit         HAS_WAIT    = (READ_LAT > 0);
    localparam int         WAIT_LOAD_I = HAS_WAIT ? READ_LAT - 1 : 0;
    // Wait timer is a down-counter; a WAIT state exits when it reads zero.
    localparam logic [7:0] WAIT_LOAD   = 8'(WAIT_LOAD_I);

    state_t     state_q, state_d;
    logic [7:0] i_q, i_d, j_q, j_d;
    logic [8:0] k_q, k_d;
    logic [7:0] si_q, si_d, sj_q, sj_d, f_q, f_d, e_q, e_d;
    logic [7:0] wait_q, wait_d;
    logic       done_q, done_d, valid_q, valid_d;
    logic [7:0] s_address_q, s_address_d, s_data_q, s_data_d;
    logic       s_wren_q, s_wren_d;
    logic [7:0] enc_address_q, enc_address_d;
    logic [7:0] dec_address_q, dec_address_d, dec_data_q, dec_data_d;
    logic       dec_wren_q, dec_wren_d;
    logic       byte_pass;

`ifdef RC4_PRGA_ASCII_CHECK_EN
    rc4_byte_check u_byte_check (
        .data (dec_data_q),
        .pass (byte_pass)
    );
`else
    assign byte_pass = 1'b1;
`endif

    always_comb begin
        state_d       = state_q;
        i_d           = i_q;
        j_d           = j_q;
        k_d           = k_q;
        si_d          = si_q;
        sj_d          = sj_q;
        f_d           = f_q;
        e_d           = e_q;
        wait_d        = wait_q;
        done_d        = done_q;
        valid_d       = valid_q;
        s_address_d   = s_address_q;
        s_data_d      = s_data_q;
        s_wren_d      = 1'b0;
        enc_address_d = enc_address_q;
        dec_address_d = dec_address_q;
        dec_data_d    = dec_data_q;
        dec_wren_d    = 1'b0;

        if (!start_flag) begin
            // Abort or idle: any write that would have been issued next is dropped.
            state_d = ST_IDLE;
            i_d     = 8'd0;
            j_d     = 8'd0;
            k_d     = 9'd0;
            done_d  = 1'b0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_INC_I;
                    i_d     = 8'd1;
                    j_d     = 8'd0;
                    k_d     = 9'd0;
                end
                ST_INC_I: begin
                    state_d     = ST_READ_I;
                    s_address_d = i_q;
                end
                ST_READ_I: begin
                    if (HAS_WAIT) begin
                        state_d = ST_WAIT_I;
                        wait_d  = WAIT_LOAD;
                    end else begin
                        state_d = ST_SAVE_I;
                        si_d    = s_q;
                    end
                end
                ST_WAIT_I: begin
                    if (wait_q == 8'd0) begin
                        state_d = ST_SAVE_I;
                        si_d    = s_q;
                    end else begin
                        wait_d = wait_q - 8'd1;
                    end
                end
                ST_SAVE_I: begin
                    state_d = ST_SET_J;
                    j_d     = j_q + si_q;
                end
                ST_SET_J: begin
                    state_d     = ST_READ_J;
                    s_address_d = j_q;
                end
                ST_READ_J: begin
                    if (HAS_WAIT) begin
                        state_d = ST_WAIT_J;
                        wait_d  = WAIT_LOAD;
                    end else begin
                        state_d = ST_SAVE_J;
                        sj_d    = s_q;
                    end
                end
                ST_WAIT_J: begin
                    if (wait_q == 8'd0) begin
                        state_d = ST_SAVE_J;
                        sj_d    = s_q;
                    end else begin
                        wait_d = wait_q - 8'd1;
                    end
                end
                ST_SAVE_J: begin
                    state_d     = ST_WRITE_I;
                    s_address_d = i_q;
                    s_data_d    = sj_q;
                    s_wren_d    = 1'b1;
                end
                ST_WRITE_I: begin
                    state_d     = ST_WRITE_J;
                    s_address_d = j_q;
                    s_data_d    = si_q;
                    s_wren_d    = 1'b1;
                end
                ST_WRITE_J: begin
                    state_d       = ST_READ_F;
                    s_address_d   = si_q + sj_q;
                    enc_address_d = k_q[7:0];
                end
                ST_READ_F: begin
                    if (HAS_WAIT) begin
                        state_d = ST_WAIT_F;
                        wait_d  = WAIT_LOAD;
                    end else begin
                        state_d = ST_SAVE_F;
                        f_d     = s_q;
                        e_d     = enc_q;
                    end
                end
                ST_WAIT_F: begin
                    if (wait_q == 8'd0) begin
                        state_d = ST_SAVE_F;
                        f_d     = s_q;
                        e_d     = enc_q;
                    end else begin
                        wait_d = wait_q - 8'd1;
                    end
                end
                ST_SAVE_F: begin
                    state_d       = ST_WRITE_DEC;
                    dec_address_d = k_q[7:0];
                    dec_data_d    = f_q ^ e_q;
                    dec_wren_d    = 1'b1;
                    k_d           = k_q + 9'd1;
                end
                ST_WRITE_DEC: begin
                    // k already counts the byte being written here.
                    if (!byte_pass || (k_q == K_LAST)) begin
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                        valid_d = byte_pass;
                    end else begin
                        state_d = ST_INC_I;
                        i_d     = i_q + 8'd1;
                    end
                end
                ST_FINISH: begin
                    state_d = ST_FINISH;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            i_q           <= 8'd0;
            j_q           <= 8'd0;
            k_q           <= 9'd0;
            si_q          <= 8'd0;
            sj_q          <= 8'd0;
            f_q           <= 8'd0;
            e_q           <= 8'd0;
            wait_q        <= 8'd0;
            done_q        <= 1'b0;
            valid_q       <= 1'b0;
            s_address_q   <= 8'd0;
            s_data_q      <= 8'd0;
            s_wren_q      <= 1'b0;
            enc_address_q <= 8'd0;
            dec_address_q <= 8'd0;
            dec_data_q    <= 8'd0;
            dec_wren_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            i_q           <= i_d;
            j_q           <= j_d;
            k_q           <= k_d;
            si_q          <= si_d;
            sj_q          <= sj_d;
            f_q           <= f_d;
            e_q           <= e_d;
            wait_q        <= wait_d;
            done_q        <= done_d;
            valid_q       <= valid_d;
            s_address_q   <= s_address_d;
            s_data_q      <= s_data_d;
            s_wren_q      <= s_wren_d;
            enc_address_q <= enc_address_d;
            dec_address_q <= dec_address_d;
            dec_data_q    <= dec_data_d;
            dec_wren_q    <= dec_wren_d;
        end
    end

    assign done_flag   = done_q;
    assign valid_flag  = valid_q;
    assign s_address   = s_address_q;
    assign s_data      = s_data_q;
    assign s_wren      = s_wren_q;
    assign enc_address = enc_address_q;
    assign dec_address = dec_address_q;
    assign dec_data    = dec_data_q;
    assign dec_wren    = dec_wren_q;

endmodule
